// File: rtl/sad_min_select.sv
// rtl/sad_min_select.sv - per-sub-block minimum SAD tracker with 2-stage pipeline and result drain
module sad_min_select #(
  parameter int SAD_W    = 16,
  parameter int NUM_LANE = 8,
  parameter int COL_W    = 5,
  parameter int ROW_W    = 7,
  localparam int LANE_W  = $clog2(NUM_LANE),
  localparam int MVX_W   = COL_W + LANE_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      search_done,
  input  logic                      sad_valid,
  input  logic [1:0]                sad_cb,
  input  logic [COL_W-1:0]          sad_col,
  input  logic [ROW_W-1:0]          sad_row,
  input  logic [NUM_LANE*SAD_W-1:0] sad_in,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [1:0]                res_cb,
  output logic [SAD_W-1:0]          res_sad,
  output logic [MVX_W-1:0]          res_mvx,
  output logic [ROW_W-1:0]          res_mvy,
  output logic                      res_hit,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FLUSH, S_OUT} state_t;

  state_t             state_q, state_d;
  logic               flush_q, flush_d;
  logic               v1_q, v1_d;
  logic [1:0]         cb1_q, cb1_d;
  logic [SAD_W-1:0]   min1_q, min1_d;
  logic [MVX_W-1:0]   mvx1_q, mvx1_d;
  logic [ROW_W-1:0]   row1_q, row1_d;
  logic [SAD_W-1:0]   best_sad_q [4];
  logic [SAD_W-1:0]   best_sad_d [4];
  logic [MVX_W-1:0]   best_mvx_q [4];
  logic [MVX_W-1:0]   best_mvx_d [4];
  logic [ROW_W-1:0]   best_mvy_q [4];
  logic [ROW_W-1:0]   best_mvy_d [4];
  logic [3:0]         hit_q, hit_d;
  logic [1:0]         res_cb_q, res_cb_d;
  logic               done_q, done_d;
  logic [SAD_W-1:0]   lane_min;
  logic [LANE_W-1:0]  lane_idx;
  logic               out_accept;

  assign out_accept = (state_q == S_OUT) && res_ready;

  // Strict less-than scan keeps the lowest lane index on ties.
  always_comb begin
    lane_min = sad_in[0 +: SAD_W];
    lane_idx = '0;
    for (int i = 1; i < NUM_LANE; i++) begin
      if (sad_in[i*SAD_W +: SAD_W] < lane_min) begin
        lane_min = sad_in[i*SAD_W +: SAD_W];
        lane_idx = LANE_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      flush_q  <= 1'b0;
      v1_q     <= 1'b0;
      cb1_q    <= '0;
      min1_q   <= '0;
      mvx1_q   <= '0;
      row1_q   <= '0;
      hit_q    <= '0;
      res_cb_q <= '0;
      done_q   <= 1'b0;
      for (int c = 0; c < 4; c++) begin
        best_sad_q[c] <= '1;
        best_mvx_q[c] <= '0;
        best_mvy_q[c] <= '0;
      end
    end else begin
      state_q    <= state_d;
      flush_q    <= flush_d;
      v1_q       <= v1_d;
      cb1_q      <= cb1_d;
      min1_q     <= min1_d;
      mvx1_q     <= mvx1_d;
      row1_q     <= row1_d;
      hit_q      <= hit_d;
      res_cb_q   <= res_cb_d;
      done_q     <= done_d;
      best_sad_q <= best_sad_d;
      best_mvx_q <= best_mvx_d;
      best_mvy_q <= best_mvy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ACCUM;
      S_ACCUM: if (search_done) state_d = S_FLUSH;
      S_FLUSH: if (flush_q) state_d = S_OUT;
      S_OUT:   if (res_ready && res_cb_q == 2'd3) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    flush_d    = (state_q == S_FLUSH) ? ~flush_q : 1'b0;
    v1_d       = (state_q == S_ACCUM) && sad_valid;
    cb1_d      = cb1_q;
    min1_d     = min1_q;
    mvx1_d     = mvx1_q;
    row1_d     = row1_q;
    best_sad_d = best_sad_q;
    best_mvx_d = best_mvx_q;
    best_mvy_d = best_mvy_q;
    hit_d      = hit_q;
    res_cb_d   = res_cb_q;
    done_d     = out_accept && (res_cb_q == 2'd3);

    if (v1_d) begin
      cb1_d  = sad_cb;
      min1_d = lane_min;
      mvx1_d = {sad_col, lane_idx};
      row1_d = sad_row;
    end

    // An unhit sub-block takes its first candidate even if it is all-ones.
    if (v1_q && (!hit_q[cb1_q] || min1_q < best_sad_q[cb1_q])) begin
      best_sad_d[cb1_q] = min1_q;
      best_mvx_d[cb1_q] = mvx1_q;
      best_mvy_d[cb1_q] = row1_q;
    end
    if (v1_q) hit_d[cb1_q] = 1'b1;

    if (state_q == S_IDLE && start) begin
      hit_d = '0;
      for (int c = 0; c < 4; c++) begin
        best_sad_d[c] = '1;
        best_mvx_d[c] = '0;
        best_mvy_d[c] = '0;
      end
    end

    if (out_accept) res_cb_d = res_cb_q + 2'd1;
    else if (state_q == S_IDLE) res_cb_d = '0;
  end

  always_comb begin
    res_valid = (state_q == S_OUT);
    res_cb    = '0;
    res_sad   = '0;
    res_mvx   = '0;
    res_mvy   = '0;
    res_hit   = 1'b0;
    if (res_valid) begin
      res_cb  = res_cb_q;
      res_sad = best_sad_q[res_cb_q];
      res_mvx = best_mvx_q[res_cb_q];
      res_mvy = best_mvy_q[res_cb_q];
      res_hit = hit_q[res_cb_q];
    end
    busy = (state_q != S_IDLE);
    done = done_q;
  end

endmodule

// File: tb/tb_sad_min_select.sv
// tb/tb_sad_min_select.sv - scoreboard bench for sad_min_select
module tb_sad_min_select;

  logic         clk = 1'b0;
  logic         rst, start, search_done, sad_valid, res_ready;
  logic [1:0]   sad_cb;
  logic [4:0]   sad_col;
  logic [6:0]   sad_row;
  logic [127:0] sad_in;
  logic         res_valid, res_hit, busy, done;
  logic [1:0]   res_cb;
  logic [15:0]  res_sad;
  logic [7:0]   res_mvx;
  logic [6:0]   res_mvy;

  typedef struct packed {
    logic [1:0]  cb;
    logic [15:0] sad;
    logic [7:0]  mvx;
    logic [6:0]  mvy;
    logic        hit;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] m_sad [4];
  logic [7:0]  m_mvx [4];
  logic [6:0]  m_mvy [4];
  logic        m_hit [4];

  sad_min_select dut (
    .clk(clk), .rst(rst), .start(start), .search_done(search_done),
    .sad_valid(sad_valid), .sad_cb(sad_cb), .sad_col(sad_col), .sad_row(sad_row),
    .sad_in(sad_in), .res_valid(res_valid), .res_ready(res_ready), .res_cb(res_cb),
    .res_sad(res_sad), .res_mvx(res_mvx), .res_mvy(res_mvy), .res_hit(res_hit),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 4; c++) begin
      m_sad[c] = 16'hFFFF; m_mvx[c] = '0; m_mvy[c] = '0; m_hit[c] = 1'b0;
    end
  endtask

  task automatic model_beat(input logic [1:0] cb, input logic [4:0] col,
                            input logic [6:0] row, input logic [127:0] lanes);
    logic [15:0] mn;
    logic [2:0]  li;
    mn = lanes[15:0];
    li = 3'd0;
    for (int j = 1; j < 8; j++)
      if (lanes[j*16 +: 16] < mn) begin mn = lanes[j*16 +: 16]; li = 3'(j); end
    if (!m_hit[cb] || mn < m_sad[cb]) begin
      m_sad[cb] = mn; m_mvx[cb] = {col, li}; m_mvy[cb] = row;
    end
    m_hit[cb] = 1'b1;
  endtask

  task automatic push_model();
    for (int c = 0; c < 4; c++)
      exp_q.push_back('{cb: 2'(c), sad: m_sad[c], mvx: m_mvx[c], mvy: m_mvy[c], hit: m_hit[c]});
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_clear();
  endtask

  task automatic beat(input logic [1:0] cb, input logic [4:0] col, input logic [6:0] row,
                      input logic [127:0] lanes, input logic last, input logic inc);
    sad_valid = 1'b1; sad_cb = cb; sad_col = col; sad_row = row; sad_in = lanes;
    search_done = last;
    if (inc) model_beat(cb, col, row, lanes);
    @(negedge clk);
    sad_valid = 1'b0; search_done = 1'b0;
  endtask

  task automatic drain(input int stall);
    exp_t e;
    int   n;
    res_ready = 1'b0;
    n = 0;
    while (!res_valid && n < 20) begin @(negedge clk); n++; end
    chk("res_valid_up", res_valid, 1);
    for (int s = 0; s < stall; s++) begin
      chk("stall_valid", res_valid, 1);
      chk("stall_cb", res_cb, exp_q[0].cb);
      chk("stall_sad", res_sad, exp_q[0].sad);
      chk("stall_mvx", res_mvx, exp_q[0].mvx);
      @(negedge clk);
    end
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      chk("out_valid", res_valid, 1);
      chk("out_cb", res_cb, e.cb);
      chk("out_sad", res_sad, e.sad);
      chk("out_mvx", res_mvx, e.mvx);
      chk("out_mvy", res_mvy, e.mvy);
      chk("out_hit", res_hit, e.hit);
      @(negedge clk);
    end
    res_ready = 1'b0;
    chk("done_pulse", done, 1);
    chk("busy_after", busy, 0);
    chk("valid_after", res_valid, 0);
    @(negedge clk);
    chk("done_clear", done, 0);
  endtask

  initial begin
    logic [127:0] l;
    rst = 1'b1; start = 0; search_done = 0; sad_valid = 0; res_ready = 0;
    sad_cb = 0; sad_col = 0; sad_row = 0; sad_in = '0;
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sad", res_sad, 0);
    rst = 1'b0;
    @(negedge clk);

    // T1: single beat, lane tie between 1 and 3 resolves to lane 1
    do_start();
    l = {8{16'd99}};
    l[15:0] = 16'd9; l[31:16] = 16'd4; l[47:32] = 16'd7; l[63:48] = 16'd4;
    beat(2'd0, 5'd3, 7'd5, l, 1'b1, 1'b1);
    exp_q.push_back('{cb: 2'd0, sad: 16'd4, mvx: 8'd25, mvy: 7'd5, hit: 1'b1});
    exp_q.push_back('{cb: 2'd1, sad: 16'hFFFF, mvx: 8'd0, mvy: 7'd0, hit: 1'b0});
    exp_q.push_back('{cb: 2'd2, sad: 16'hFFFF, mvx: 8'd0, mvy: 7'd0, hit: 1'b0});
    exp_q.push_back('{cb: 2'd3, sad: 16'hFFFF, mvx: 8'd0, mvy: 7'd0, hit: 1'b0});
    drain(0);

    // T2: strictly smaller wins; equal keeps earliest
    do_start();
    beat(2'd2, 5'd0, 7'd1, {8{16'd10}}, 1'b0, 1'b1);
    beat(2'd2, 5'd0, 7'd2, {8{16'd10}}, 1'b0, 1'b1);
    beat(2'd2, 5'd0, 7'd3, {8{16'd8}},  1'b1, 1'b1);
    push_model();
    drain(0);
    do_start();
    beat(2'd2, 5'd0, 7'd1, {8{16'd10}}, 1'b0, 1'b1);
    beat(2'd2, 5'd0, 7'd2, {8{16'd10}}, 1'b1, 1'b1);
    exp_q.push_back('{cb: 2'd0, sad: 16'hFFFF, mvx: 8'd0, mvy: 7'd0, hit: 1'b0});
    exp_q.push_back('{cb: 2'd1, sad: 16'hFFFF, mvx: 8'd0, mvy: 7'd0, hit: 1'b0});
    exp_q.push_back('{cb: 2'd2, sad: 16'd10, mvx: 8'd0, mvy: 7'd1, hit: 1'b1});
    exp_q.push_back('{cb: 2'd3, sad: 16'hFFFF, mvx: 8'd0, mvy: 7'd0, hit: 1'b0});
    // T4: consumer stalls 5 cycles before accepting
    drain(5);

    // T3: beat with search_done is kept, the next one is dropped
    do_start();
    l = {8{16'd50}}; l[95:80] = 16'd2;
    beat(2'd1, 5'd4, 7'd6, l, 1'b1, 1'b1);
    beat(2'd1, 5'd9, 7'd9, {8{16'd1}}, 1'b0, 1'b0);
    push_model();
    drain(0);

    // T5: reset mid-accumulation aborts everything
    do_start();
    for (int i = 0; i < 3; i++) beat(2'd0, 5'(i), 7'(i), {8{16'(i + 1)}}, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_valid", res_valid, 0);
    chk("abort_sad", res_sad, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_start();
    l = {8{16'd200}}; l[111:96] = 16'd5;
    beat(2'd3, 5'd7, 7'd9, l, 1'b1, 1'b1);
    push_model();
    drain(0);

    // T6: 64 back-to-back random beats across all sub-blocks
    do_start();
    for (int i = 0; i < 64; i++) begin
      for (int j = 0; j < 8; j++) l[j*16 +: 16] = 16'($urandom_range(0, 500));
      beat(2'(i % 4), 5'($urandom_range(0, 31)), 7'($urandom_range(0, 127)), l,
           i == 63, 1'b1);
    end
    push_model();
    drain(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
